// File: rtl/pe.sv
// Processing element for a weight-stationary systolic array.
// Double-buffered weights: a shadow register collects the next weight while
// the active register feeds the MAC. A switch copies shadow into active, and
// the copy takes effect for the following cycle's MAC.
// All arithmetic is signed Q8.8. The product and the accumulate both saturate.
// Every output comes straight from a flop, so no input reaches an output
// through logic alone.
module pe (
   input  logic        clk,
   input  logic        rst,
   input  logic        pe_valid_in,
   input  logic        pe_accept_w_in,
   input  logic [15:0] pe_input_in,
   input  logic [15:0] pe_weight_in,
   input  logic [15:0] pe_psum_in,
   input  logic        pe_switch_in,
   output logic        pe_valid_out,
   output logic [15:0] pe_input_out,
   output logic [15:0] pe_weight_out,
   output logic [15:0] pe_psum_out
);

   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;

   logic [15:0]        weight_shadow;
   logic [15:0]        weight_active;

   logic signed [31:0] prod_full;
   logic signed [23:0] prod_shift;
   logic [15:0]        prod_sat;
   logic signed [16:0] sum_wide;
   logic [15:0]        sum_sat;

   // MAC datapath. It uses the pre-edge active weight, so a switch in the
   // same cycle does not affect this cycle's result.
   always_comb begin
      prod_full  = $signed(pe_input_in) * $signed(weight_active);
      // Dropping the low 8 bits of a signed value is an arithmetic shift
      // right by 8, which rounds towards minus infinity.
      prod_shift = prod_full[31:8];

      // Q16.8 -> Q8.8: clamp when the upper bits are not a sign extension
      // of bit 15.
      if (!prod_shift[23] && (|prod_shift[22:15])) begin
         prod_sat = SAT_MAX;
      end else if (prod_shift[23] && !(&prod_shift[22:15])) begin
         prod_sat = SAT_MIN;
      end else begin
         prod_sat = prod_shift[15:0];
      end

      // 17-bit sum cannot wrap; clamp on disagreement of the top two bits.
      sum_wide = $signed({pe_psum_in[15], pe_psum_in}) + $signed({prod_sat[15], prod_sat});
      if (sum_wide[16] != sum_wide[15]) begin
         sum_sat = sum_wide[16] ? SAT_MIN : SAT_MAX;
      end else begin
         sum_sat = sum_wide[15:0];
      end
   end

   // Weight double buffer. The active register always copies the old shadow
   // value, even when a new weight arrives in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weight_shadow <= '0;
         weight_active <= '0;
      end else begin
         if (pe_accept_w_in) begin
            weight_shadow <= pe_weight_in;
         end
         if (pe_switch_in) begin
            weight_active <= weight_shadow;
         end
      end
   end

   // Weight forwarding to the neighbour. The forwarded weight is zero
   // whenever no weight is being accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_weight_out <= '0;
      end else begin
         pe_weight_out <= pe_accept_w_in ? pe_weight_in : 16'h0000;
      end
   end

   // Valid pipeline, one cycle of latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_valid_out <= 1'b0;
      end else begin
         pe_valid_out <= pe_valid_in;
      end
   end

   // Activation forward and partial-sum result. Both are zero when the
   // input is invalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_input_out <= '0;
         pe_psum_out  <= '0;
      end else if (pe_valid_in) begin
         pe_input_out <= pe_input_in;
         pe_psum_out  <= sum_sat;
      end else begin
         pe_input_out <= '0;
         pe_psum_out  <= '0;
      end
   end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed cases followed by random traffic.
// Results are checked against an arithmetic reference model.
module tb_pe;

   logic        clk;
   logic        rst;
   logic        pe_valid_in;
   logic        pe_accept_w_in;
   logic [15:0] pe_input_in;
   logic [15:0] pe_weight_in;
   logic [15:0] pe_psum_in;
   logic        pe_switch_in;
   logic        pe_valid_out;
   logic [15:0] pe_input_out;
   logic [15:0] pe_weight_out;
   logic [15:0] pe_psum_out;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   longint      m_shadow = 0;
   longint      m_active = 0;
   logic        e_valid;
   logic [15:0] e_input;
   logic [15:0] e_weight;
   logic [15:0] e_psum;

   pe dut (
      .clk            (clk),
      .rst            (rst),
      .pe_valid_in    (pe_valid_in),
      .pe_accept_w_in (pe_accept_w_in),
      .pe_input_in    (pe_input_in),
      .pe_weight_in   (pe_weight_in),
      .pe_psum_in     (pe_psum_in),
      .pe_switch_in   (pe_switch_in),
      .pe_valid_out   (pe_valid_out),
      .pe_input_out   (pe_input_out),
      .pe_weight_out  (pe_weight_out),
      .pe_psum_out    (pe_psum_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] clamp16(longint x);
      if (x > 32767)       return 16'h7FFF;
      else if (x < -32768) return 16'h8000;
      else                 return x[15:0];
   endfunction

   function automatic longint sx(logic [15:0] v);
      return longint'($signed(v));
   endfunction

   task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Apply one cycle of inputs and advance the model with the same inputs.
   task automatic drive(logic v, logic acc, logic sw, logic [15:0] din,
                        logic [15:0] w, logic [15:0] ps);
      longint prod;
      pe_valid_in    = v;
      pe_accept_w_in = acc;
      pe_switch_in   = sw;
      pe_input_in    = din;
      pe_weight_in   = w;
      pe_psum_in     = ps;
      prod     = (sx(din) * m_active) >>> 8;
      e_valid  = v;
      e_input  = v ? din : 16'h0000;
      e_weight = acc ? w : 16'h0000;
      e_psum   = v ? clamp16(sx(ps) + sx(clamp16(prod))) : 16'h0000;
      if (sw)  m_active = m_shadow;
      if (acc) m_shadow = sx(w);
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      #1;
      check({tag, ".valid"},  {15'd0, pe_valid_out}, {15'd0, e_valid});
      check({tag, ".input"},  pe_input_out,  e_input);
      check({tag, ".weight"}, pe_weight_out, e_weight);
      check({tag, ".psum"},   pe_psum_out,   e_psum);
   endtask

   task automatic check_zero(string tag);
      check({tag, ".valid"},  {15'd0, pe_valid_out}, 16'h0000);
      check({tag, ".input"},  pe_input_out,  16'h0000);
      check({tag, ".weight"}, pe_weight_out, 16'h0000);
      check({tag, ".psum"},   pe_psum_out,   16'h0000);
   endtask

   task automatic drive_random_raw();
      pe_valid_in    = 1'($urandom);
      pe_accept_w_in = 1'($urandom);
      pe_switch_in   = 1'($urandom);
      pe_input_in    = 16'($urandom);
      pe_weight_in   = 16'($urandom);
      pe_psum_in     = 16'($urandom);
   endtask

   initial begin
      // reset held with inputs toggling; outputs must be zero before any edge
      rst = 1'b0;
      drive_random_raw();
      #2;
      check_zero("rst_noedge");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive_random_raw();
         @(posedge clk);
         #1;
         check_zero("rst_hold");
      end
      drive(0, 0, 0, 16'h0, 16'h0, 16'h0);
      rst = 1'b1;
      tick("rel_idle");
      check_zero("rel_zero");

      // weight load and forward
      drive(0, 1, 0, 16'h0, 16'h4500, 16'h0);
      tick("acc1");
      check("acc1.lit", pe_weight_out, 16'h4500);
      drive(0, 1, 0, 16'h0, 16'h0A00, 16'h0);
      tick("acc2");
      check("acc2.lit", pe_weight_out, 16'h0A00);
      drive(0, 0, 0, 16'h0, 16'h1234, 16'h0);
      tick("acc0");
      check("acc0.lit", pe_weight_out, 16'h0000);

      // switch timing: the MAC in the switch cycle still uses the old weight
      drive(1, 0, 1, 16'h0200, 16'h0, 16'h3200);
      tick("sw");
      check("sw.psum.lit", pe_psum_out, 16'h3200);
      check("sw.in.lit", pe_input_out, 16'h0200);
      drive(1, 0, 0, 16'h0200, 16'h0, 16'h3200);
      tick("mac10");
      check("mac10.lit", pe_psum_out, 16'h4600);
      drive(0, 0, 0, 16'h0200, 16'h0, 16'h3200);
      tick("inv");

      // accept and switch in the same cycle
      drive(0, 1, 0, 16'h0, 16'h0100, 16'h0);
      tick("sim_pre");
      drive(0, 1, 1, 16'h0, 16'h0300, 16'h0);
      tick("sim");
      drive(1, 0, 0, 16'h0100, 16'h0, 16'h0000);
      tick("sim_mac");
      check("sim_mac.lit", pe_psum_out, 16'h0100);
      drive(0, 0, 1, 16'h0, 16'h0, 16'h0);
      tick("sim_sw2");
      drive(1, 0, 0, 16'h0100, 16'h0, 16'h0000);
      tick("sim_mac2");
      check("sim_mac2.lit", pe_psum_out, 16'h0300);

      // saturation and sign
      drive(0, 1, 0, 16'h0, 16'h7F00, 16'h0);
      tick("s1_ld");
      drive(0, 0, 1, 16'h0, 16'h0, 16'h0);
      tick("s1_sw");
      drive(1, 0, 0, 16'h7F00, 16'h0, 16'h0000);
      tick("s1");
      check("satpos.lit", pe_psum_out, 16'h7FFF);
      drive(0, 1, 0, 16'h0, 16'h0300, 16'h0);
      tick("s2_ld");
      drive(0, 0, 1, 16'h0, 16'h0, 16'h0);
      tick("s2_sw");
      drive(1, 0, 0, 16'hFE00, 16'h0, 16'h0100);
      tick("s2");
      check("neg.lit", pe_psum_out, 16'hFB00);
      drive(1, 0, 0, 16'hFE00, 16'h0, 16'h8000);
      tick("s3");
      check("satneg.lit", pe_psum_out, 16'h8000);
      drive(1, 0, 0, 16'h8000, 16'h0, 16'h0000);
      tick("s4");

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom), ($urandom % 4) == 0, ($urandom % 5) == 0,
               16'($urandom), 16'($urandom), 16'($urandom));
         tick("rnd");
      end

      // reset mid-cycle; all state is discarded without a clock edge
      drive(1, 1, 1, 16'h0100, 16'h2000, 16'h0100);
      tick("pre_rst");
      #2;
      rst = 1'b0;
      #1;
      check_zero("mid_rst");
      @(negedge clk);
      drive_random_raw();
      @(posedge clk);
      #1;
      check_zero("mid_rst_hold");
      m_shadow = 0;
      m_active = 0;
      drive(1, 0, 1, 16'h0400, 16'h0, 16'h0123);
      rst = 1'b1;
      tick("post_rst");
      check("post_rst.lit", pe_psum_out, 16'h0123);
      for (int i = 0; i < 100; i++) begin
         drive(1'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0,
               16'($urandom), 16'($urandom), 16'($urandom));
         tick("rnd2");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pe.md
PE -- requirements
Module: pe

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- pe_valid_in  input  1  input/psum operands valid this cycle.
- pe_accept_w_in  input  1  load pe_weight_in into the shadow weight register this cycle.
- pe_input_in  input  16  activation operand, signed Q8.8.
- pe_weight_in  input  16  weight operand, signed Q8.8.
- pe_psum_in  input  16  incoming partial sum, signed Q8.8.
- pe_switch_in  input  1  copy the shadow weight into the active weight register.
- pe_valid_out  output  1  registered copy of pe_valid_in.
- pe_input_out  output  16  registered activation forwarded to the neighbouring PE.
- pe_weight_out  output  16  registered weight forwarded to the neighbouring PE.
- pe_psum_out  output  16  registered partial-sum result, signed Q8.8.
REQ-002 The module SHALL use one clock (clk) with an asynchronous, active-low reset (rst).
REQ-003 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-004 The module SHALL hold two internal 16-bit registers: weight_shadow and weight_active.
REQ-005 When pe_accept_w_in=1 at a rising edge: weight_shadow <= pe_weight_in and pe_weight_out <= pe_weight_in.
- When pe_accept_w_in=0: weight_shadow holds its value and pe_weight_out <= 0.
REQ-006 When pe_switch_in=1 at a rising edge: weight_active <= the pre-edge value of weight_shadow.
- If pe_switch_in and pe_accept_w_in are both 1 in the same cycle, weight_active takes the old shadow value and weight_shadow takes the new pe_weight_in.
REQ-007 pe_valid_out <= pe_valid_in at every rising edge; the valid latency SHALL be 1 cycle.
REQ-008 When pe_valid_in=1 at a rising edge:
- pe_input_out <= pe_input_in.
- pe_psum_out <= sat16(pe_psum_in + prod), where prod = sat16((pe_input_in * weight_active) >>> 8).
- weight_active here is the pre-edge value, so a switch in the same cycle does not affect that cycle's MAC.
REQ-009 When pe_valid_in=0 at a rising edge: pe_input_out <= 0 and pe_psum_out <= 0.
REQ-010 Arithmetic rules:
- All operands are two's-complement Q8.8.
- The product is a full 32-bit signed Q16.16 value, arithmetically shifted right 8 bits (floor rounding).
- The addition uses at least 17 bits.
- sat16 SHALL clamp to [0x8000, 0x7FFF] (-128.0 to +127.996).
REQ-011 Input values SHALL be sampled only at rising edges; no input has any other side effect.

Reset
REQ-012 While rst=0, the following SHALL be forced to 0 immediately, without waiting for a clock edge:
- weight_shadow, weight_active
- pe_valid_out, pe_input_out, pe_weight_out, pe_psum_out
REQ-013 A reset asserted mid-operation SHALL discard all loaded weights; the PE computes with weight 0 until a new accept then switch occurs.
REQ-014 Normal operation SHALL resume at the first rising edge after rst returns to 1.

Verification
REQ-015 Reset: rst=0 with random inputs toggling -> all outputs 0 with no clock edge required; after release, first edge with all controls 0 -> outputs remain 0.
REQ-016 Weight load and forward:
- accept=1 with weight 0x4500 (69.0), then accept=1 with 0x0A00 (10.0) -> pe_weight_out 0x4500 then 0x0A00.
- Then accept=0 -> pe_weight_out 0x0000.
REQ-017 Switch timing, continuing from REQ-016 (shadow=0x0A00, active=0):
- switch=1, valid=1, input 0x0200 (2.0), psum 0x3200 (50.0) -> pe_psum_out 0x3200 (active still 0), pe_input_out 0x0200, pe_valid_out 1.
- Next edge, same operands with valid=1 -> pe_psum_out 0x4600 (70.0).
- Next edge with valid=0 -> valid_out 0, psum_out 0, input_out 0.
REQ-018 Simultaneous events: accept=1 with weight 0x0300 and switch=1 in the same cycle, shadow previously 0x0100 -> active=0x0100, shadow=0x0300; a following MAC with input 0x0100 and psum 0 -> psum_out 0x0100.
REQ-019 Saturation and sign, each case separately:
- input 0x7F00, active 0x7F00, psum 0 -> psum_out 0x7FFF.
- input 0xFE00 (-2.0), active 0x0300 (3.0), psum 0x0100 -> psum_out 0xFB00 (-5.0).
- psum 0x8000 plus a negative product -> psum_out 0x8000.
